// File: rtl/tsc_display_pkg.sv
// Shared display constants: the active-low hex-to-segment table, the blank and
// dash patterns, and the display state encoding.
package tsc_display_pkg;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Entry n is the segment pattern (g..a, active-low) for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic {
    SHOW_EMPTY = 1'b0,
    SHOW_DATA  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/wwd_display_buffer_if.sv
// Board-side bundle of the WWD display buffer: CPU trace inputs, step/clear
// controls, and the display/LED/status outputs.
interface wwd_display_buffer_if;
  logic        wwd_valid;
  logic [15:0] wwd_data;
  logic [7:0]  pc_low;
  logic        step_btn;
  logic        clear;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  led;
  logic        empty;
  logic        full;
  logic        overflow;

  modport master (
    output wwd_valid, wwd_data, pc_low, step_btn, clear,
    input  seg, an, led, empty, full, overflow
  );

  modport slave (
    input  wwd_valid, wwd_data, pc_low, step_btn, clear,
    output seg, an, led, empty, full, overflow
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_seg7
  import tsc_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[hex];
endmodule

// File: rtl/wwd_display_buffer.sv
// Captures WWD values into a small FIFO and scans the oldest one onto a 4-digit
// display; a synchronized step button pops the shown entry.
module wwd_display_buffer
  import tsc_display_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input logic                 clk,
  input logic                 reset_n,
  wwd_display_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          ovf_q, ovf_d, empty_q, full_q;
  logic          do_push, do_pop;
  logic          sync1, sync2, sync3, step_evt;
  disp_state_e   state, state_d;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [6:0]    digit_seg, seg_q;
  logic [3:0]    an_q;
  logic [7:0]    led_q;
  logic [15:0]   head;

  // Two flops into the core clock domain, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      step_evt <= 1'b0;
    end else begin
      sync1    <= bus.step_btn;
      sync2    <= sync1;
      sync3    <= sync2;
      step_evt <= sync2 & ~sync3;
    end
  end

  // A push while full still succeeds if the same cycle frees a slot.
  always_comb begin
    do_pop  = step_evt && (count != '0);
    do_push = bus.wwd_valid && ((count != FULL_CNT) || do_pop);
    count_d = count;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (bus.wwd_valid && !do_push) ovf_d = 1'b1;
      if (do_push && !do_pop)      count_d = count + CNT_ONE;
      else if (do_pop && !do_push) count_d = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count   <= count_d;
      ovf_q   <= ovf_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
      if (bus.clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !bus.clear) mem[wr_ptr] <= bus.wwd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SHOW_EMPTY;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      SHOW_EMPTY: if (count_d != '0) state_d = SHOW_DATA;
      SHOW_DATA:  if (count_d == '0) state_d = SHOW_EMPTY;
      default:    state_d = SHOW_EMPTY;
    endcase
  end

  assign head = mem[rd_ptr];

  hex_to_seg7 u_dec (
    .hex(head[{digit_idx, 2'b00} +: 4]),
    .seg(digit_seg)
  );

  // seg and an are registered from the same digit index so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= 4'b1111;
      led_q       <= '0;
    end else begin
      if (refresh_cnt == DIV_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end
      seg_q <= (state == SHOW_DATA) ? digit_seg : SEG_DASH;
      an_q  <= ~(4'b0001 << digit_idx);
      led_q <= bus.pc_low;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.led      = led_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overflow = ovf_q;
endmodule
